imem_port_sched: RTL

//  Arbitrates the single instruction-memory port between instruction fetch (PC register)
//  and LWI data reads issued from the EX_DM stage; sequences the PC stall and pipeline flushes.

---
 rtl/imem_port_sched.sv | 135 +++++++++++++
 1 files changed

// File: rtl/imem_port_sched.sv
// rtl/imem_port_sched.sv - instruction-memory port arbiter between fetch and LWI reads, with redirect flush sequencing
// Optional PERF_CNT_EN adds saturating LWI-stall and flush-entry counters.
module imem_port_sched #(
  parameter int LWI_LAT   = 1,
  parameter int FLUSH_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_hazard,
  input  logic        lwi_req,
  input  logic        flow_change,
  input  logic        btb_hit_ID_EX,
`ifdef PERF_CNT_EN
  output logic [15:0] perf_lwi_stall,
  output logic [15:0] perf_flush,
`endif
  output logic        stall_IM_ID,
  output logic        imem_sel_lwi,
  output logic        lwi_data_vld,
  output logic        flush_IM_ID,
  output logic        flush_ID_EX,
  output logic        redirect_pend
);

  typedef enum logic [1:0] {RUN, LWI_RD, FLUSH} state_t;

  localparam logic [2:0] LWI_INIT   = 3'(LWI_LAT - 1);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       sel_q;
  logic       vld_q;
  logic       flush_q;
  logic       pend_now;
  logic       enter_flush;
  logic       unused_ok;

  // A hit and a miss both redirect; the hit bit only tells the BTB it mispredicted.
  assign unused_ok = btb_hit_ID_EX;

  // A redirect arriving in the final LWI cycle is consumed at once instead of being lost.
  assign pend_now    = redirect_pend | flow_change;
  assign enter_flush = ((state == RUN) && !lwi_req && flow_change) ||
                       ((state == LWI_RD) && (cnt == 3'd0) && pend_now);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      cnt           <= 3'd0;
      redirect_pend <= 1'b0;
      sel_q         <= 1'b0;
      vld_q         <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (lwi_req) begin
            state         <= LWI_RD;
            cnt           <= LWI_INIT;
            sel_q         <= 1'b1;
            vld_q         <= (LWI_INIT == 3'd0);
            flush_q       <= 1'b0;
            redirect_pend <= flow_change;
          end else if (flow_change) begin
            state   <= FLUSH;
            cnt     <= FLUSH_INIT;
            sel_q   <= 1'b0;
            vld_q   <= 1'b0;
            flush_q <= 1'b1;
          end
        end
        LWI_RD: begin
          if (cnt == 3'd0) begin
            sel_q         <= 1'b0;
            vld_q         <= 1'b0;
            redirect_pend <= 1'b0;
            if (pend_now) begin
              state   <= FLUSH;
              cnt     <= FLUSH_INIT;
              flush_q <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else begin
            cnt           <= cnt - 3'd1;
            vld_q         <= (cnt == 3'd1);
            redirect_pend <= pend_now;
          end
        end
        FLUSH: begin
          if (cnt == 3'd0) begin
            state   <= RUN;
            flush_q <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state         <= RUN;
          cnt           <= 3'd0;
          redirect_pend <= 1'b0;
          sel_q         <= 1'b0;
          vld_q         <= 1'b0;
          flush_q       <= 1'b0;
        end
      endcase
    end
  end

  // Squash wins over any freeze request.
  assign stall_IM_ID  = (stall_hazard | sel_q) & ~flush_q;
  assign imem_sel_lwi = sel_q;
  assign lwi_data_vld = vld_q;
  assign flush_IM_ID  = flush_q;
  assign flush_ID_EX  = flush_q;

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lwi_stall <= 16'd0;
      perf_flush     <= 16'd0;
    end else begin
      if ((state == LWI_RD) && (perf_lwi_stall != 16'hFFFF))
        perf_lwi_stall <= perf_lwi_stall + 16'd1;
      if (enter_flush && (perf_flush != 16'hFFFF))
        perf_flush <= perf_flush + 16'd1;
    end
  end
`else
  logic unused_enter;
  assign unused_enter = enter_flush;
`endif

endmodule
